// File: rtl/vw_command_controller.sv
// Turns toggle-handshaked virtual-wire commands into one-cycle register-bus strobes.
// Each response goes back on the probe as a single registered update.
module vw_command_controller #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 6,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W+ADDR_W+2:0] vw_source,
    output logic [DATA_W+2:0]        vw_probe,
    output logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_wdata,
    output logic                     reg_wr_en,
    output logic                     reg_rd_en,
    output logic                     reg_pulse,
    input  logic                     reg_rd_valid,
    input  logic [DATA_W-1:0]        reg_rdata,
    output logic                     busy
);
    localparam int SRC_W  = DATA_W + ADDR_W + 3;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_PULSE = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {IDLE, SETTLE, EXEC, RD_WAIT, RESP} state_t;

    state_t              state;
    logic [SRC_W-1:0]    snapshot;
    logic [SCNT_W-1:0]   settle_cnt;
    logic [TCNT_W-1:0]   timer;
    logic                ack_toggle;
    logic [1:0]          status;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          resp_status;
    logic [DATA_W-1:0]   resp_rdata;

    logic                src_req;
    logic                snap_req;
    logic [1:0]          snap_op;
    logic [ADDR_W-1:0]   snap_addr;
    logic [DATA_W-1:0]   snap_wdata;

    assign src_req    = vw_source[SRC_W-1];
    assign snap_req   = snapshot[SRC_W-1];
    assign snap_op    = snapshot[SRC_W-2 -: 2];
    assign snap_addr  = snapshot[DATA_W +: ADDR_W];
    assign snap_wdata = snapshot[DATA_W-1:0];

    // The probe is one register group so the host never sees a torn response.
    assign vw_probe = {ack_toggle, status, rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            snapshot    <= '0;
            settle_cnt  <= '0;
            timer       <= '0;
            ack_toggle  <= src_req;
            status      <= ST_OK;
            rdata       <= '0;
            resp_status <= ST_OK;
            resp_rdata  <= '0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_pulse   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (src_req != ack_toggle) begin
                        snapshot   <= vw_source;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (snap_req == ack_toggle) begin
                        // Host withdrew the request before it settled.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (vw_source != snapshot) begin
                        snapshot   <= vw_source;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SCNT_W'(SETTLE_CYCLES - 1)) begin
                        // Strobes are registered here so they are high exactly during EXEC.
                        reg_addr  <= snap_addr;
                        reg_wdata <= snap_wdata;
                        reg_wr_en <= (snap_op == OP_WRITE);
                        reg_rd_en <= (snap_op == OP_READ);
                        reg_pulse <= (snap_op == OP_PULSE);
                        state     <= EXEC;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    resp_status <= ST_OK;
                    resp_rdata  <= '0;
                    timer       <= '0;
                    state       <= (snap_op == OP_READ) ? RD_WAIT : RESP;
                end
                RD_WAIT: begin
                    if (reg_rd_valid) begin
                        resp_status <= ST_OK;
                        resp_rdata  <= reg_rdata;
                        state       <= RESP;
                    end else if (timer == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_status <= ST_TIMEOUT;
                        resp_rdata  <= '0;
                        state       <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    ack_toggle <= snap_req;
                    status     <= resp_status;
                    rdata      <= resp_rdata;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
